// File: rtl/vga_timing_gen.sv
// VGA raster timing: coordinates, display enable, sync and line/frame pulses; one register stage, no backpressure.
// Define VGA_SYNC_PIPE_EN to delay hsync/vsync by one extra cycle to match a registered colour stage.
module vga_timing_gen #(
    parameter int   H_VISIBLE  = 800,
    parameter int   H_FRONT    = 56,
    parameter int   H_SYNC     = 120,
    parameter int   H_BACK     = 64,
    parameter int   V_VISIBLE  = 600,
    parameter int   V_FRONT    = 37,
    parameter int   V_SYNC     = 6,
    parameter int   V_BACK     = 23,
    parameter logic H_SYNC_POL = 1'b1,
    parameter logic V_SYNC_POL = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [10:0] o_h_coord,
    output logic [9:0]  o_v_coord,
    output logic        o_disp_enbl,
    output logic        o_hsync,
    output logic        o_vsync,
    output logic        o_line_start,
    output logic        o_frame_start
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

    generate
        if (H_TOTAL > 2048) begin : g_h_total_err
            $error("vga_timing_gen: H_TOTAL exceeds 2048");
        end
        if (V_TOTAL > 1024) begin : g_v_total_err
            $error("vga_timing_gen: V_TOTAL exceeds 1024");
        end
    endgenerate

    logic [10:0] h_q, h_d;
    logic [9:0]  v_q, v_d;
    logic        disp_q, disp_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        line_q, line_d;
    logic        frame_q, frame_d;
    logic        h_wrap;
    logic        h_in_sync;
    logic        v_in_sync;

    always_comb begin
        h_wrap = (h_q == H_LAST);
        h_d    = h_wrap ? 11'd0 : h_q + 11'd1;
        v_d    = v_q;
        if (h_wrap) begin
            v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        end
    end

    // Decode from the next counter values so every registered output matches the coordinates.
    always_comb begin
        h_in_sync = ({1'b0, h_d} >= 12'(HS_START)) && ({1'b0, h_d} < 12'(HS_END));
        v_in_sync = ({1'b0, v_d} >= 11'(VS_START)) && ({1'b0, v_d} < 11'(VS_END));
        disp_d    = ({1'b0, h_d} < 12'(H_VISIBLE)) && ({1'b0, v_d} < 11'(V_VISIBLE));
        hsync_d   = h_in_sync ? H_SYNC_POL : ~H_SYNC_POL;
        vsync_d   = v_in_sync ? V_SYNC_POL : ~V_SYNC_POL;
        line_d    = (h_d == 11'd0);
        frame_d   = (h_d == 11'd0) && (v_d == 10'd0);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h_q     <= H_LAST;
            v_q     <= V_LAST;
            disp_q  <= 1'b0;
            hsync_q <= ~H_SYNC_POL;
            vsync_q <= ~V_SYNC_POL;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            disp_q  <= disp_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            line_q  <= line_d;
            frame_q <= frame_d;
        end
    end

`ifdef VGA_SYNC_PIPE_EN
    logic hsync_pipe_q, hsync_pipe_d;
    logic vsync_pipe_q, vsync_pipe_d;

    always_comb begin
        hsync_pipe_d = hsync_q;
        vsync_pipe_d = vsync_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hsync_pipe_q <= ~H_SYNC_POL;
            vsync_pipe_q <= ~V_SYNC_POL;
        end else begin
            hsync_pipe_q <= hsync_pipe_d;
            vsync_pipe_q <= vsync_pipe_d;
        end
    end

    assign o_hsync = hsync_pipe_q;
    assign o_vsync = vsync_pipe_q;
`else
    assign o_hsync = hsync_q;
    assign o_vsync = vsync_q;
`endif

    assign o_h_coord     = h_q;
    assign o_v_coord     = v_q;
    assign o_disp_enbl   = disp_q;
    assign o_line_start  = line_q;
    assign o_frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: default horizontal timing, shortened vertical timing to keep runs short.
module tb_vga_timing_gen;

    localparam int HV = 800, HF = 56, HS = 120, HB = 64;
    localparam int VV = 6, VF = 3, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int RST_K = 5 + 2 * FRAME + 3 * HT + 400 + 1;
    localparam int N_CYC = RST_K + 2000;

    typedef struct packed {
        logic [10:0] h;
        logic [9:0]  v;
        logic        disp;
        logic        hs;
        logic        vs;
        logic        ls;
        logic        fs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] h_coord;
    logic [9:0]  v_coord;
    logic        disp, hsync, vsync, line_start, frame_start;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   mcyc  = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .o_h_coord    (h_coord),
        .o_v_coord    (v_coord),
        .o_disp_enbl  (disp),
        .o_hsync      (hsync),
        .o_vsync      (vsync),
        .o_line_start (line_start),
        .o_frame_start(frame_start)
    );

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", nm, mcyc, act, req);
        end
    endtask

    // Pixel n of the raster since reset release, counted by division rather than wrap logic.
    function automatic exp_t model(input int n);
        exp_t e;
        int   hh, vv;
        hh     = n % HT;
        vv     = (n / HT) % VT;
        e.h    = 11'(hh);
        e.v    = 10'(vv);
        e.disp = (hh < HV) && (vv < VV);
        e.hs   = (hh >= HV + HF) && (hh < HV + HF + HS);
        e.vs   = (vv >= VV + VF) && (vv < VV + VF + VS);
        e.ls   = (hh == 0);
        e.fs   = (hh == 0) && (vv == 0);
        return e;
    endfunction

    initial begin
        int   n;
        exp_t e;
        logic prev_hs, prev_vs, cur_hs, cur_vs;
        n       = 0;
        prev_hs = 1'b0;
        prev_vs = 1'b0;
        rst     = 1'b1;
        for (int k = 0; k < N_CYC; k++) begin
            @(negedge clk);
            rst = (k < 5) || (k == RST_K);
            if (rst) begin
                e.h    = 11'(HT - 1);
                e.v    = 10'(VT - 1);
                e.disp = 1'b0;
                e.hs   = 1'b0;
                e.vs   = 1'b0;
                e.ls   = 1'b0;
                e.fs   = 1'b0;
                n      = 0;
            end else begin
                e = model(n);
                n++;
            end
            cur_hs = e.hs;
            cur_vs = e.vs;
`ifdef VGA_SYNC_PIPE_EN
            e.hs    = rst ? 1'b0 : prev_hs;
            e.vs    = rst ? 1'b0 : prev_vs;
`endif
            prev_hs = rst ? 1'b0 : cur_hs;
            prev_vs = rst ? 1'b0 : cur_vs;
            exp_q.push_back(e);
        end
        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        exp_t e;
        int   last_ls, last_fs, hs_cnt, vs_cnt, disp_cnt;
        last_ls  = -1;
        last_fs  = -1;
        hs_cnt   = 0;
        vs_cnt   = 0;
        disp_cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            mcyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("h_coord", int'(h_coord), int'(e.h));
                chk("v_coord", int'(v_coord), int'(e.v));
                chk("disp_enbl", int'(disp), int'(e.disp));
                chk("hsync", int'(hsync), int'(e.hs));
                chk("vsync", int'(vsync), int'(e.vs));
                chk("line_start", int'(line_start), int'(e.ls));
                chk("frame_start", int'(frame_start), int'(e.fs));
            end
            if (rst) begin
                last_ls  = -1;
                last_fs  = -1;
                hs_cnt   = 0;
                vs_cnt   = 0;
                disp_cnt = 0;
            end else begin
                if (line_start === 1'b1) begin
                    if (last_ls >= 0) begin
                        chk("line_period", mcyc - last_ls, HT);
                        chk("hsync_width", hs_cnt, HS);
                    end
                    last_ls = mcyc;
                    hs_cnt  = 0;
                end
                if (frame_start === 1'b1) begin
                    if (last_fs >= 0) begin
                        chk("frame_period", mcyc - last_fs, FRAME);
                        chk("vsync_cycles", vs_cnt, VS * HT);
                        chk("disp_cycles", disp_cnt, HV * VV);
                    end
                    last_fs  = mcyc;
                    vs_cnt   = 0;
                    disp_cnt = 0;
                end
                if (hsync === 1'b1) hs_cnt++;
                if (vsync === 1'b1) vs_cnt++;
                if (disp === 1'b1) disp_cnt++;
            end
        end
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the VGA raster timing that the pixel/graphic stage consumes: display enable, horizontal/vertical pixel coordinates, and hsync/vsync to the connector.
- Sits between the pixel clock domain root and the graphic colour generator; the colour stage drives o_red/o_green/o_blue combinationally from this block's outputs.
- Defaults are 800x600 @ 72 Hz, which requires a 50 MHz pixel clock.

Parameters:
- H_VISIBLE, 800, visible pixels per line
- H_FRONT, 56, horizontal front porch (pixels)
- H_SYNC, 120, hsync pulse width (pixels)
- H_BACK, 64, horizontal back porch (pixels)
- V_VISIBLE, 600, visible lines per frame
- V_FRONT, 37, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BACK, 23, vertical back porch (lines)
- H_SYNC_POL, 1, hsync active level (1 = active-high)
- V_SYNC_POL, 1, vsync active level

Ports:
- i_clk  in  1  pixel clock
- i_rst  in  1  synchronous reset, active-high
- o_h_coord  out  11  horizontal counter, 0..H_TOTAL-1
- o_v_coord  out  10  vertical counter, 0..V_TOTAL-1
- o_disp_enbl  out  1  high when o_h_coord < H_VISIBLE and o_v_coord < V_VISIBLE
- o_hsync  out  1  horizontal sync to connector
- o_vsync  out  1  vertical sync to connector
- o_line_start  out  1  one-cycle pulse when o_h_coord == 0
- o_frame_start  out  1  one-cycle pulse when o_h_coord == 0 and o_v_coord == 0

Behaviour:
- Totals and width limits:
  - H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 1040).
  - V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (default 666).
  - Elaboration error if H_TOTAL > 2048 or V_TOTAL > 1024.
- Registers: o_h_coord and o_v_coord are the counter registers themselves. All other outputs are registers computed from the next counter values, so every output describes the same pixel in the same cycle. There is no combinational path from counters to outputs.
- Reset values (while i_rst high):
  - o_h_coord = H_TOTAL-1, o_v_coord = V_TOTAL-1.
  - o_disp_enbl = 0, o_line_start = 0, o_frame_start = 0.
  - o_hsync = !H_SYNC_POL, o_vsync = !V_SYNC_POL.
- First edge after reset release: outputs show pixel (0,0) with o_disp_enbl = 1, o_line_start = 1, o_frame_start = 1.
- Horizontal counting: h increments every cycle. At H_TOTAL-1 it wraps to 0.
- Vertical counting: v increments only on an h wrap. At v = V_TOTAL-1 with h wrapping, v wraps to 0.
- hsync: active when h is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), inactive otherwise. Default active range is h 856..975.
- vsync: active when v is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC), independent of h. Default active range is v 637..642.
- Blanking: o_disp_enbl is 0 throughout front porch, sync and back porch, both horizontal and vertical.
- Frame length: exactly H_TOTAL*V_TOTAL cycles (default 692640) with no drift.
- Reset mid-frame: reset takes effect on the next edge, with no partial-line completion. The restart is identical to power-up.
- Coordinates beyond the visible area are still driven. Downstream truncation to $clog2(width) bits is legal only while o_disp_enbl = 1.

Optional Feature:
- Macro: VGA_SYNC_PIPE_EN.
- With the macro defined:
  - o_hsync and o_vsync pass through one extra register stage, lagging the coordinates by one cycle.
  - The purpose is to align sync with a downstream registered colour stage.
  - The extra stage resets to the inactive level.
  - o_disp_enbl, the coordinates and the pulses are unchanged.
- Without the macro: sync is aligned with the coordinates as described in Behaviour.

Test Plan:
- Reset release: hold i_rst 5 cycles, then release -> during reset h = 1039, v = 665, hsync/vsync = 0, disp = 0; first edge after release gives h = 0, v = 0, disp = 1, frame_start = 1.
- Line timing: run one line -> disp high for 800 consecutive cycles (h 0..799); hsync high exactly for h 856..975 (120 cycles); line_start period = 1040 cycles.
- Frame timing: run 2 frames -> vsync high for v 637..642 (6*1040 cycles); frame_start period = 692640; disp = 0 for all v >= 600.
- Wrap corner: at h = 1039, v = 665 -> next cycle h = 0, v = 0; at h = 1039, v = 10 -> next cycle h = 0, v = 11.
- Mid-frame reset: assert i_rst at h = 400, v = 300 for 1 cycle -> following cycle equals the reset values; the next edge is (0,0) with frame_start = 1.
- VGA_SYNC_PIPE_EN defined: hsync rises when h = 857 and falls when h = 976; coordinates and disp are identical to the undefined build.
